// File: rtl/adma_dm_dst_pkg.sv
// adma_dm_dst_pkg
// Shared types for the AXI-Stream destination data mover:
//   - field widths of a transfer descriptor (ID / TID, beats-1 length, TDEST)
//   - FSM state encoding
//   - descriptor struct stored in the outstanding-descriptor queue
//   - last-beat helper used by the stream FSM
package adma_dm_dst_pkg;

  localparam int MST_ID_W    = 5;
  localparam int ATX_LEN_W   = 8;
  localparam int DST_TDEST_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } dst_state_e;

  typedef struct packed {
    logic [MST_ID_W-1:0]    id;
    logic [ATX_LEN_W-1:0]   len;
    logic [DST_TDEST_W-1:0] tdest;
  } dst_desc_t;

  // Length is encoded as beats-1, so the beat whose index equals len is the last.
  function automatic logic desc_last_beat(input logic [ATX_LEN_W-1:0] cnt,
                                          input logic [ATX_LEN_W-1:0] len);
    return (cnt == len);
  endfunction

endpackage

// File: rtl/adma_dm_dst_info_fifo.sv
// adma_dm_dst_info_fifo
// Synchronous FIFO of descriptor structs with first-word fall-through read.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and descriptor (ignored when full)
//   pop             read request (ignored when empty)
//   pop_data        head of the queue, valid while !empty
//   full, empty     occupancy flags
// DEPTH must be a power of 2 and at least 2; pointers carry one extra wrap bit.
module adma_dm_dst_info_fifo
  import adma_dm_dst_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  dst_desc_t push_data,
  input  logic      pop,
  output dst_desc_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  dst_desc_t   mem_q [DEPTH];
  logic        push_en_s;
  logic        pop_en_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en_s = push && !full;
  assign pop_en_s  = pop && !empty;
  assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted push / pop requests.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_en_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
    end
  end

endmodule

// File: rtl/adma_dm_dst_axis.sv
// adma_dm_dst_axis
// Transmit end of the DMA stream path: turns queued descriptors plus their
// write-data beats into AXI-Stream packets (one per descriptor, TLAST on the
// final beat) and returns one completion ID per packet once its last beat has
// been accepted downstream.
// Ports:
//   aclk, areset                       clock, asynchronous active-high reset
//   atx_awid/awlen/tdest, vld, rdy     descriptor handshake (rdy = queue not full)
//   atx_wdata/wstrb, wdata_vld/rdy     data beat handshake
//   atx_done_id, done_vld, done_rdy    completion handshake
//   m_t*                               AXI-Stream master, single output register
// Build option: ADMA_DM_DST_TKEEP_EN drives TKEEP from the beat strobes
// (null bytes removed); otherwise TKEEP is all ones. TSTRB is always the strobes.
module adma_dm_dst_axis
  import adma_dm_dst_pkg::*;
#(
  parameter int DMA_CHN_NUM      = 4,
  parameter int ATX_DST_DATA_W   = 256,
  parameter int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
  parameter int ATX_NUM_OSTD     = DMA_CHN_NUM
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [MST_ID_W-1:0]         atx_awid,
  input  logic [ATX_LEN_W-1:0]        atx_awlen,
  input  logic [DST_TDEST_W-1:0]      atx_tdest,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]   atx_wdata,
  input  logic [ATX_DST_BYTE_AMT-1:0] atx_wstrb,
  input  logic                        atx_wdata_vld,
  output logic                        atx_wdata_rdy,
  output logic [MST_ID_W-1:0]         atx_done_id,
  output logic                        atx_done_vld,
  input  logic                        atx_done_rdy,
  output logic [MST_ID_W-1:0]         m_tid_o,
  output logic [DST_TDEST_W-1:0]      m_tdest_o,
  output logic [ATX_DST_DATA_W-1:0]   m_tdata_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tkeep_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tstrb_o,
  output logic                        m_tlast_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i
);

  dst_state_e                  state_q, state_d;
  logic [ATX_LEN_W-1:0]        cnt_q, cnt_d;
  dst_desc_t                   cur_q, cur_d;
  logic                        m_tvalid_q, m_tvalid_d;
  logic                        m_tlast_q, m_tlast_d;
  logic [ATX_DST_DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [ATX_DST_BYTE_AMT-1:0] m_tstrb_q, m_tstrb_d;
  logic [ATX_DST_BYTE_AMT-1:0] m_tkeep_q, m_tkeep_d;
  logic [MST_ID_W-1:0]         m_tid_q, m_tid_d;
  logic [DST_TDEST_W-1:0]      m_tdest_q, m_tdest_d;
  logic                        done_vld_q, done_vld_d;
  logic [MST_ID_W-1:0]         done_id_q, done_id_d;

  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic                        fifo_pop_s;
  dst_desc_t                   fifo_head_s;
  dst_desc_t                   fifo_in_s;
  logic                        load_en_s;
  logic                        data_hs_s;
  logic [ATX_DST_BYTE_AMT-1:0] beat_keep_s;

  assign fifo_in_s = '{id: atx_awid, len: atx_awlen, tdest: atx_tdest};

  adma_dm_dst_info_fifo #(
    .DEPTH (ATX_NUM_OSTD)
  ) u_info_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (atx_vld),
    .push_data (fifo_in_s),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

`ifdef ADMA_DM_DST_TKEEP_EN
  assign beat_keep_s = atx_wstrb;
`else
  assign beat_keep_s = {ATX_DST_BYTE_AMT{1'b1}};
`endif

  // The output register may take a new beat when empty or being drained this cycle.
  assign load_en_s     = !m_tvalid_q || m_tready_i;
  assign atx_wdata_rdy = (state_q == STREAM) && load_en_s;
  assign data_hs_s     = atx_wdata_rdy && atx_wdata_vld;
  assign atx_rdy       = !fifo_full_s;

  // Next-state logic for the packet FSM, output register and completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    m_tstrb_d  = m_tstrb_q;
    m_tkeep_d  = m_tkeep_q;
    m_tid_d    = m_tid_q;
    m_tdest_d  = m_tdest_q;
    done_vld_d = done_vld_q;
    done_id_d  = done_id_q;
    fifo_pop_s = 1'b0;

    if (load_en_s) begin
      m_tvalid_d = data_hs_s;
      if (data_hs_s) begin
        m_tdata_d = atx_wdata;
        m_tstrb_d = atx_wstrb;
        m_tkeep_d = beat_keep_s;
        m_tid_d   = cur_q.id;
        m_tdest_d = cur_q.tdest;
        m_tlast_d = desc_last_beat(cnt_q, cur_q.len);
      end else begin
        m_tlast_d = m_tlast_q;
      end
    end else begin
      m_tvalid_d = m_tvalid_q;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          cur_d      = fifo_head_s;
          cnt_d      = '0;
          state_d    = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (data_hs_s) begin
          // Counter stops at len, so a maximum-length packet never wraps.
          if (desc_last_beat(cnt_q, cur_q.len)) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + ATX_LEN_W'(1);
          end
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        if (m_tvalid_q && m_tready_i && m_tlast_q) begin
          done_vld_d = 1'b1;
          done_id_d  = cur_q.id;
          state_d    = RESP;
        end else begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        if (atx_done_rdy) begin
          done_vld_d = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, current descriptor, stream and completion registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tstrb_q  <= '0;
      m_tkeep_q  <= '0;
      m_tid_q    <= '0;
      m_tdest_q  <= '0;
      done_vld_q <= 1'b0;
      done_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      m_tstrb_q  <= m_tstrb_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tid_q    <= m_tid_d;
      m_tdest_q  <= m_tdest_d;
      done_vld_q <= done_vld_d;
      done_id_q  <= done_id_d;
    end
  end

  assign m_tvalid_o   = m_tvalid_q;
  assign m_tlast_o    = m_tlast_q;
  assign m_tdata_o    = m_tdata_q;
  assign m_tstrb_o    = m_tstrb_q;
  assign m_tkeep_o    = m_tkeep_q;
  assign m_tid_o      = m_tid_q;
  assign m_tdest_o    = m_tdest_q;
  assign atx_done_vld = done_vld_q;
  assign atx_done_id  = done_id_q;

endmodule

// File: tb/tb_adma_dm_dst_axis.sv
// tb_adma_dm_dst_axis
// Randomized bench for adma_dm_dst_axis. Packets are described as lists of
// descriptors and beats; the expected stream is the in-order concatenation of
// every packet's beats (TLAST on the final one) and the expected completions
// are the packet IDs in push order.
module tb_adma_dm_dst_axis;
  import adma_dm_dst_pkg::*;

  localparam int DW = 256;
  localparam int BW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [BW-1:0] strb;
  } beat_t;

  typedef struct {
    logic [MST_ID_W-1:0]    id;
    logic [DST_TDEST_W-1:0] tdest;
    logic [DW-1:0]          data;
    logic [BW-1:0]          strb;
    logic                   last;
  } exp_beat_t;

  logic                   aclk;
  logic                   areset;
  logic [MST_ID_W-1:0]    atx_awid;
  logic [ATX_LEN_W-1:0]   atx_awlen;
  logic [DST_TDEST_W-1:0] atx_tdest;
  logic                   atx_vld;
  logic                   atx_rdy;
  logic [DW-1:0]          atx_wdata;
  logic [BW-1:0]          atx_wstrb;
  logic                   atx_wdata_vld;
  logic                   atx_wdata_rdy;
  logic [MST_ID_W-1:0]    atx_done_id;
  logic                   atx_done_vld;
  logic                   atx_done_rdy;
  logic [MST_ID_W-1:0]    m_tid_o;
  logic [DST_TDEST_W-1:0] m_tdest_o;
  logic [DW-1:0]          m_tdata_o;
  logic [BW-1:0]          m_tkeep_o;
  logic [BW-1:0]          m_tstrb_o;
  logic                   m_tlast_o;
  logic                   m_tvalid_o;
  logic                   m_tready_i;

  adma_dm_dst_axis dut (
    .aclk          (aclk),
    .areset        (areset),
    .atx_awid      (atx_awid),
    .atx_awlen     (atx_awlen),
    .atx_tdest     (atx_tdest),
    .atx_vld       (atx_vld),
    .atx_rdy       (atx_rdy),
    .atx_wdata     (atx_wdata),
    .atx_wstrb     (atx_wstrb),
    .atx_wdata_vld (atx_wdata_vld),
    .atx_wdata_rdy (atx_wdata_rdy),
    .atx_done_id   (atx_done_id),
    .atx_done_vld  (atx_done_vld),
    .atx_done_rdy  (atx_done_rdy),
    .m_tid_o       (m_tid_o),
    .m_tdest_o     (m_tdest_o),
    .m_tdata_o     (m_tdata_o),
    .m_tkeep_o     (m_tkeep_o),
    .m_tstrb_o     (m_tstrb_o),
    .m_tlast_o     (m_tlast_o),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i)
  );

  dst_desc_t   desc_q [$];
  beat_t       beat_q [$];
  exp_beat_t   exp_q [$];
  logic [MST_ID_W-1:0] exp_done [$];

  int   n_checks;
  int   n_errors;
  int   beats_seen;
  int   rdy_mode;     // 0: always ready, 1: toggle, 2: random
  logic done_hold;
  logic desc_fire;
  logic data_fire;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input logic [MST_ID_W-1:0] id, input logic [ATX_LEN_W-1:0] len,
                         input logic [DST_TDEST_W-1:0] tdest);
    beat_t     b;
    exp_beat_t e;
    desc_q.push_back('{id: id, len: len, tdest: tdest});
    for (int i = 0; i <= int'(len); i++) begin
      for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom();
      b.strb  = $urandom();
      beat_q.push_back(b);
      e.id    = id;
      e.tdest = tdest;
      e.data  = b.data;
      e.strb  = b.strb;
      e.last  = (i == int'(len));
      exp_q.push_back(e);
    end
    exp_done.push_back(id);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_done.size() != 0 || desc_q.size() != 0) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check_eq(tag, DW'(n < budget), DW'(1));
    repeat (3) @(negedge aclk);
  endtask

  // Input driver: presents queue heads after each rising edge.
  initial begin
    atx_vld = 1'b0; atx_awid = '0; atx_awlen = '0; atx_tdest = '0;
    atx_wdata_vld = 1'b0; atx_wdata = '0; atx_wstrb = '0;
    atx_done_rdy = 1'b0; m_tready_i = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (areset) begin
        atx_vld = 1'b0; atx_wdata_vld = 1'b0; atx_done_rdy = 1'b0; m_tready_i = 1'b0;
        desc_fire = 1'b0; data_fire = 1'b0;
      end else begin
        if (desc_fire && desc_q.size() > 0) desc_q.delete(0);
        if (data_fire && beat_q.size() > 0) beat_q.delete(0);
        desc_fire = 1'b0;
        data_fire = 1'b0;
        atx_vld = (desc_q.size() > 0) && ($urandom_range(0, 3) != 0);
        if (desc_q.size() > 0) begin
          atx_awid  = desc_q[0].id;
          atx_awlen = desc_q[0].len;
          atx_tdest = desc_q[0].tdest;
        end
        atx_wdata_vld = (beat_q.size() > 0) && ($urandom_range(0, 4) != 0);
        if (beat_q.size() > 0) begin
          atx_wdata = beat_q[0].data;
          atx_wstrb = beat_q[0].strb;
        end
        case (rdy_mode)
          0:       m_tready_i = 1'b1;
          1:       m_tready_i = ~m_tready_i;
          default: m_tready_i = ($urandom_range(0, 2) != 0);
        endcase
        atx_done_rdy = !done_hold && ($urandom_range(0, 1) != 0);
      end
    end
  end

  // Monitor: scoreboard on stream and completion handshakes, stall stability.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [71:0]   prev_ctl;
    logic [71:0]   ctl;
    exp_beat_t     e;
    logic [BW-1:0] exp_keep;
    prev_stall = 1'b0; prev_data = '0; prev_ctl = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
        desc_fire  = 1'b0;
        data_fire  = 1'b0;
      end else begin
        ctl = {m_tid_o, m_tdest_o, m_tkeep_o, m_tstrb_o, m_tlast_o};
        if (prev_stall) begin
          check_eq("stall_data", m_tdata_o, prev_data);
          check_eq("stall_ctl", DW'(ctl), DW'(prev_ctl));
          check_eq("stall_vld", DW'(m_tvalid_o), DW'(1));
        end
        prev_stall = m_tvalid_o && !m_tready_i;
        prev_data  = m_tdata_o;
        prev_ctl   = ctl;
        if (m_tvalid_o && m_tready_i) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", DW'(1), DW'(0));
          end else begin
            e = exp_q.pop_front();
`ifdef ADMA_DM_DST_TKEEP_EN
            exp_keep = e.strb;
`else
            exp_keep = {BW{1'b1}};
`endif
            check_eq("tdata", m_tdata_o, e.data);
            check_eq("tstrb", DW'(m_tstrb_o), DW'(e.strb));
            check_eq("tkeep", DW'(m_tkeep_o), DW'(exp_keep));
            check_eq("tid", DW'(m_tid_o), DW'(e.id));
            check_eq("tdest", DW'(m_tdest_o), DW'(e.tdest));
            check_eq("tlast", DW'(m_tlast_o), DW'(e.last));
            beats_seen++;
          end
        end
        if (atx_done_vld && atx_done_rdy) begin
          if (exp_done.size() == 0) check_eq("unexpected_done", DW'(1), DW'(0));
          else check_eq("done_id", DW'(atx_done_id), DW'(exp_done.pop_front()));
        end
        desc_fire = atx_vld && atx_rdy;
        data_fire = atx_wdata_vld && atx_wdata_rdy;
      end
    end
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    n_checks = 0; n_errors = 0; beats_seen = 0;
    rdy_mode = 0; done_hold = 1'b0; desc_fire = 1'b0; data_fire = 1'b0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Reset state on the first cycle after release.
    @(negedge aclk);
    check_eq("rst_tvalid", DW'(m_tvalid_o), DW'(0));
    check_eq("rst_done_vld", DW'(atx_done_vld), DW'(0));
    check_eq("rst_atx_rdy", DW'(atx_rdy), DW'(1));
    check_eq("rst_wdata_rdy", DW'(atx_wdata_rdy), DW'(0));
    check_eq("rst_tlast", DW'(m_tlast_o), DW'(0));
    check_eq("rst_tdata", m_tdata_o, DW'(0));
    check_eq("rst_tid", DW'(m_tid_o), DW'(0));
    check_eq("rst_done_id", DW'(atx_done_id), DW'(0));

    // Basic 4-beat packet, single-beat packet, maximum-length packet.
    rdy_mode = 0;
    add_pkt(5'd3, 8'd3, 2'd1);
    wait_idle("pkt_basic", 200);
    add_pkt(5'd5, 8'd0, 2'($urandom()));
    wait_idle("pkt_len0", 200);
    rdy_mode = 2;
    add_pkt(5'd1, 8'd255, 2'd2);
    wait_idle("pkt_maxlen", 3000);

    // Alternating ready during a 4-beat packet.
    rdy_mode = 1;
    add_pkt(5'd7, 8'd3, 2'd2);
    wait_idle("pkt_toggle", 200);

    // Completion held off; queue fills while the FSM waits in RESP.
    rdy_mode = 0;
    done_hold = 1'b1;
    add_pkt(5'd9, 8'd1, 2'd0);
    n = 0;
    while (!atx_done_vld && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check_eq("resp_reached", DW'(atx_done_vld), DW'(1));
    for (int i = 0; i < 4; i++) add_pkt(5'(20 + i), 8'($urandom_range(0, 2)), 2'(i));
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("resp_done_vld", DW'(atx_done_vld), DW'(1));
      check_eq("resp_done_id", DW'(atx_done_id), DW'(9));
      check_eq("resp_wdata_rdy", DW'(atx_wdata_rdy), DW'(0));
    end
    n = 0;
    while (desc_q.size() != 0 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    check_eq("full_atx_rdy", DW'(atx_rdy), DW'(0));
    check_eq("full_done_vld", DW'(atx_done_vld), DW'(1));
    done_hold = 1'b0;
    wait_idle("pkt_fifo_order", 500);

    // Random traffic.
    rdy_mode = 2;
    for (int i = 0; i < 25; i++) begin
      add_pkt(5'($urandom()), 8'($urandom_range(0, 7)), 2'($urandom()));
    end
    wait_idle("pkt_random", 5000);

    // Reset in the middle of a 4-beat packet.
    rdy_mode = 0;
    beats_seen = 0;
    add_pkt(5'd11, 8'd3, 2'd1);
    n = 0;
    while (beats_seen < 2 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check_eq("mid_reach_beat2", DW'(beats_seen), DW'(2));
    @(posedge aclk);
    #1 areset = 1'b1;
    desc_q.delete(); beat_q.delete(); exp_q.delete(); exp_done.delete();
    #1;
    check_eq("mid_rst_tvalid", DW'(m_tvalid_o), DW'(0));
    check_eq("mid_rst_done_vld", DW'(atx_done_vld), DW'(0));
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check_eq("mid_rel_atx_rdy", DW'(atx_rdy), DW'(1));
    check_eq("mid_rel_wdata_rdy", DW'(atx_wdata_rdy), DW'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check_eq("mid_rel_quiet", DW'({m_tvalid_o, atx_done_vld, atx_wdata_rdy}), DW'(0));
    end

    // Recovery after reset.
    add_pkt(5'd13, 8'd2, 2'd3);
    wait_idle("pkt_after_reset", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
